mole_game_ctrl: RTL and testbench
=================================

Name: mole_game_ctrl

Overview:
- Game controller for the whack-a-mole design. It sits directly upstream of the game timer.
- It turns a start key into the game-running signal (game_start) and consumes the timer's time-up flag (timer_signal).
- It raises game_done when play ends.
- During play it lights one pseudo-random mole LED at a time, detects hits on the key inputs and keeps a two-digit BCD score for the hex display path.

Parameters:
- NUM_MOLES, 4: number of mole LEDs/hit keys. Must be a power of two, 2..8.
- TICK_DIV, 25000000: Clock cycles per game tick (0.5 s at 50 MHz).
- MOLE_UP_TICKS, 3: ticks a mole stays lit before it counts as a miss.
- LFSR_SEED, 8'hA5: reset value of the LFSR. Must be non-zero.

Ports:
- Clock, input, 1: system clock (50 MHz).
- reset, input, 1: asynchronous, active-low reset.
- start_key, input, 1: start request, level, already synchronous to Clock. Rising edge acts.
- hit_keys, input, NUM_MOLES: one key per mole, synchronous level. Rising edge acts.
- timer_signal, input, 1: from the game timer. 1 means game time has expired.
- game_start, output, 1: game running. Drives the timer's Game input.
- game_done, output, 1: game over. Drives the timer's enable input.
- mole_leds, output, NUM_MOLES: one-hot lit mole, or all zero.
- hit_pulse, output, 1: one-cycle pulse per scored hit.
- score_ones, output, 4: BCD ones digit of the score.
- score_tens, output, 4: BCD tens digit of the score.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - game_start, game_done, mole_leds, hit_pulse, score_ones and score_tens all go to 0.
  - LFSR goes to LFSR_SEED. Edge-detect registers, tick counter, up-tick count and previous mole index go to 0.
- Edge detect: prev_start and prev_hit registers. A rising edge is `in & ~prev`, evaluated combinationally in the same cycle the input is sampled high.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every cycle in every non-reset state.
- FSM states: IDLE, SPAWN, UP, HIT, DONE.
  - IDLE: all outputs 0. On a start rising edge: clear the score and go to SPAWN.
  - SPAWN (1 cycle): idx = lfsr[log2(NUM_MOLES)-1:0]. If idx equals the previous index, use (idx+1) mod NUM_MOLES. Store idx, clear the tick counter and up-tick count, go to UP.
  - UP:
    - mole_leds = one-hot(idx).
    - The tick counter counts 0..TICK_DIV-1. Each wrap increments the up-tick count.
    - A hit_keys rising edge on bit idx goes to HIT. Edges on other bits are ignored, with no penalty. A simultaneous edge on idx plus other bits still counts as a hit.
    - When the up-tick count reaches MOLE_UP_TICKS: miss, go to SPAWN, score unchanged.
  - HIT (1 cycle): mole_leds=0, hit_pulse=1. Score increments in BCD (ones 9 wraps to 0 and carries into tens). Score saturates at 99. Then go to SPAWN.
  - DONE: game_done=1, mole_leds=0, score held. A start rising edge clears the score and goes to SPAWN.
- game_start=1 in SPAWN, UP and HIT; 0 in IDLE and DONE. game_done=1 only in DONE.
- timer_signal=1 in SPAWN, UP or HIT: go to DONE on the next edge, with priority over hit and timeout. A hit in the same cycle is not scored. If HIT is the current state, its increment still completes.
- timer_signal is ignored in IDLE and DONE. start_key is ignored in SPAWN, UP and HIT.
- Latency:
  - Hit key high at posedge k (low at k-1): state becomes HIT after edge k. hit_pulse is high for cycle k..k+1. The score is updated after edge k+1.
  - The new mole lights 2 cycles after leaving HIT or a timeout.
- Reset mid-game: immediate return to IDLE. The score is lost.

Decomposition:
- Package mole_game_pkg holds:
  - state enum (IDLE, SPAWN, UP, HIT, DONE);
  - LFSR tap mask;
  - default LFSR_SEED;
  - BCD digit max (4'd9);
  - score saturation constant (99).
- One sub-module, score_bcd_counter:
  - inputs: Clock, reset, clear, inc;
  - outputs: ones, tens;
  - behaviour: two-digit BCD count with saturation at 99.
- LFSR and FSM stay inline.

Test Plan (bench overrides: TICK_DIV=4, MOLE_UP_TICKS=3, NUM_MOLES=4):
1. Reset held low mid-UP, then released -> all outputs 0, state IDLE. A start pulse -> game_start=1 within 1 cycle, a one-hot mole_leds value 2 cycles after the start edge.
2. Mole lit at idx=2, hit_keys 0000->0100 -> hit_pulse high exactly 1 cycle, score 00->01, mole_leds=0 during HIT, a new mole with index ≠2 lit 2 cycles later.
3. No hits -> mole stays lit exactly 12 cycles (3 ticks × 4), then re-spawns. Score stays 00, hit_pulse never asserted.
4. Wrong key (bit 0 while idx=3) -> no score, mole stays lit. Keys 1001 together -> scored as a hit.
5. Preload 09 via 9 hits, hit once -> score 10. From 99, another hit -> score stays 99, hit_pulse still pulses.
6. timer_signal=1 in the same cycle as a valid hit edge -> DONE, game_done=1, game_start=0, score unchanged. A start edge in DONE -> score 00, game_start=1.

Source files
------------

// File: rtl/mole_game_pkg.sv
// Shared types and constants for the whack-a-mole game controller.
package mole_game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SPAWN,
    UP,
    HIT,
    DONE
  } state_t;

  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3.
  localparam logic [7:0] LFSR_TAP_MASK     = 8'hB8;
  localparam logic [7:0] DEFAULT_LFSR_SEED = 8'hA5;
  localparam logic [3:0] BCD_DIGIT_MAX     = 4'd9;
  // Score ceiling of 99, held as two packed BCD digits {tens, ones}.
  localparam logic [7:0] SCORE_SAT_BCD     = 8'h99;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAP_MASK)};
  endfunction

endpackage

// File: rtl/score_bcd_counter.sv
// Two-digit BCD score counter that saturates at 99.
module score_bcd_counter
  import mole_game_pkg::*;
(
  input  logic       Clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] ones,
  output logic [3:0] tens
);

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      ones <= 4'd0;
      tens <= 4'd0;
    end else if (clear) begin
      ones <= 4'd0;
      tens <= 4'd0;
    end else if (inc && ({tens, ones} != SCORE_SAT_BCD)) begin
      if (ones == BCD_DIGIT_MAX) begin
        ones <= 4'd0;
        tens <= tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game controller: start/stop handshake with the game timer,
// pseudo-random mole selection, hit detection and BCD scoring.
module mole_game_ctrl
  import mole_game_pkg::*;
#(
  parameter int         NUM_MOLES     = 4,
  parameter int         TICK_DIV      = 25000000,
  parameter int         MOLE_UP_TICKS = 3,
  parameter logic [7:0] LFSR_SEED     = DEFAULT_LFSR_SEED
) (
  input  logic                 Clock,
  input  logic                 reset,
  input  logic                 start_key,
  input  logic [NUM_MOLES-1:0] hit_keys,
  input  logic                 timer_signal,
  output logic                 game_start,
  output logic                 game_done,
  output logic [NUM_MOLES-1:0] mole_leds,
  output logic                 hit_pulse,
  output logic [3:0]           score_ones,
  output logic [3:0]           score_tens
);

  localparam int IDX_W  = $clog2(NUM_MOLES);
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int UP_W   = $clog2(MOLE_UP_TICKS + 1);

  state_t               state, next_state;
  logic [7:0]           lfsr;
  logic                 prev_start;
  logic [NUM_MOLES-1:0] prev_hit;
  logic [IDX_W-1:0]     mole_idx, spawn_idx;
  logic [TICK_W-1:0]    tick_cnt;
  logic [UP_W-1:0]      up_cnt;

  logic                 start_rise;
  logic [NUM_MOLES-1:0] hit_rise;
  logic                 tick_wrap;
  logic                 mole_timeout;
  logic                 score_clear;
  logic                 score_inc;

  assign start_rise   = start_key & ~prev_start;
  assign hit_rise     = hit_keys & ~prev_hit;
  assign tick_wrap    = (tick_cnt == TICK_W'(TICK_DIV - 1));
  // The wrap that would bring the up-tick count to MOLE_UP_TICKS ends the mole.
  assign mole_timeout = tick_wrap && (up_cnt == UP_W'(MOLE_UP_TICKS - 1));

  // Never light the same hole twice in a row.
  always_comb begin
    spawn_idx = lfsr[IDX_W-1:0];
    if (spawn_idx == mole_idx) begin
      spawn_idx = spawn_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      lfsr       <= LFSR_SEED;
      prev_start <= 1'b0;
      prev_hit   <= '0;
      mole_idx   <= '0;
      tick_cnt   <= '0;
      up_cnt     <= '0;
    end else begin
      lfsr       <= lfsr_next(lfsr);
      prev_start <= start_key;
      prev_hit   <= hit_keys;
      if (state == SPAWN) begin
        mole_idx <= spawn_idx;
        tick_cnt <= '0;
        up_cnt   <= '0;
      end else if (state == UP) begin
        tick_cnt <= tick_wrap ? '0 : tick_cnt + TICK_W'(1);
        if (tick_wrap) begin
          up_cnt <= up_cnt + UP_W'(1);
        end
      end
    end
  end

  always_comb begin
    next_state  = state;
    game_start  = 1'b0;
    game_done   = 1'b0;
    mole_leds   = '0;
    hit_pulse   = 1'b0;
    score_clear = 1'b0;
    score_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (start_rise) begin
          score_clear = 1'b1;
          next_state  = SPAWN;
        end
      end
      SPAWN: begin
        game_start = 1'b1;
        next_state = timer_signal ? DONE : UP;
      end
      UP: begin
        game_start = 1'b1;
        mole_leds  = NUM_MOLES'(1) << mole_idx;
        // Time-up beats a hit, which beats the mole timing out.
        if (timer_signal) begin
          next_state = DONE;
        end else if (hit_rise[mole_idx]) begin
          next_state = HIT;
        end else if (mole_timeout) begin
          next_state = SPAWN;
        end
      end
      HIT: begin
        game_start = 1'b1;
        hit_pulse  = 1'b1;
        score_inc  = 1'b1;
        next_state = timer_signal ? DONE : SPAWN;
      end
      DONE: begin
        game_done = 1'b1;
        if (start_rise) begin
          score_clear = 1'b1;
          next_state  = SPAWN;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  score_bcd_counter u_score (
    .Clock (Clock),
    .reset (reset),
    .clear (score_clear),
    .inc   (score_inc),
    .ones  (score_ones),
    .tens  (score_tens)
  );

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Scoreboard bench for mole_game_ctrl: a game-level reference model predicts
// the outputs after every clock edge and a separate monitor compares them.
module tb_mole_game_ctrl;

  localparam int N   = 4;
  localparam int TD  = 4;
  localparam int UPT = 3;

  logic         Clock = 1'b0;
  logic         reset = 1'b0;
  logic         start_key = 1'b0;
  logic [N-1:0] hit_keys = '0;
  logic         timer_signal = 1'b0;
  logic         game_start, game_done, hit_pulse;
  logic [N-1:0] mole_leds;
  logic [3:0]   score_ones, score_tens;

  typedef struct packed {
    logic       gs;
    logic       gd;
    logic [3:0] leds;
    logic       hp;
    logic [3:0] tens;
    logic [3:0] ones;
  } expect_t;

  expect_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: game phase flags, integer score, lit-cycle age.
  bit m_running, m_over, m_spawning, m_hitting, m_prev_s;
  int m_lit, m_last, m_age, m_score, m_lfsr, m_prev_h;

  mole_game_ctrl #(
    .NUM_MOLES     (N),
    .TICK_DIV      (TD),
    .MOLE_UP_TICKS (UPT),
    .LFSR_SEED     (8'hA5)
  ) dut (
    .Clock        (Clock),
    .reset        (reset),
    .start_key    (start_key),
    .hit_keys     (hit_keys),
    .timer_signal (timer_signal),
    .game_start   (game_start),
    .game_done    (game_done),
    .mole_leds    (mole_leds),
    .hit_pulse    (hit_pulse),
    .score_ones   (score_ones),
    .score_tens   (score_tens)
  );

  always #5 Clock = ~Clock;

  function automatic void modelReset();
    m_running = 0; m_over = 0; m_spawning = 0; m_hitting = 0; m_prev_s = 0;
    m_lit = 0; m_last = 0; m_age = 0; m_score = 0; m_lfsr = 'hA5; m_prev_h = 0;
  endfunction

  function automatic bit moleUp();
    return m_running && !m_spawning && !m_hitting;
  endfunction

  function automatic expect_t modelOutputs();
    expect_t e;
    e.gs   = m_running;
    e.gd   = m_over;
    e.leds = moleUp() ? 4'(1 << m_lit) : 4'd0;
    e.hp   = m_hitting;
    e.tens = 4'(m_score / 10);
    e.ones = 4'(m_score % 10);
    return e;
  endfunction

  function automatic void modelStep(input bit s, input int h, input bit t);
    bit sr = s && !m_prev_s;
    int hr = h & ~m_prev_h & 'hF;
    int idx;
    if (!m_running) begin
      if (sr) begin
        m_score = 0; m_running = 1; m_over = 0; m_spawning = 1;
      end
    end else if (m_spawning) begin
      idx = m_lfsr % N;
      if (idx == m_last) idx = (idx + 1) % N;
      m_last = idx;
      m_spawning = 0;
      if (t) begin
        m_running = 0; m_over = 1;
      end else begin
        m_lit = idx; m_age = 0;
      end
    end else if (m_hitting) begin
      if (m_score < 99) m_score = m_score + 1;
      m_hitting = 0;
      if (t) begin
        m_running = 0; m_over = 1;
      end else begin
        m_spawning = 1;
      end
    end else begin
      if (t) begin
        m_running = 0; m_over = 1;
      end else if (((hr >> m_lit) & 1) == 1) begin
        m_hitting = 1;
      end else begin
        m_age = m_age + 1;
        if (m_age == TD * UPT) m_spawning = 1;
      end
    end
    m_lfsr = ((m_lfsr << 1) & 'hFF) | ($countones(m_lfsr & 'hB8) & 1);
    m_prev_s = s;
    m_prev_h = h;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic driveCycle(input bit s, input logic [3:0] h, input bit t);
    start_key = s;
    hit_keys = h;
    timer_signal = t;
    modelStep(s, int'(h), t);
    exp_q.push_back(modelOutputs());
  endtask

  task automatic applyStimulus(input bit s, input logic [3:0] h, input bit t);
    @(negedge Clock);
    driveCycle(s, h, t);
  endtask

  task automatic doReset();
    expect_t e;
    @(negedge Clock);
    start_key = 0; hit_keys = '0; timer_signal = 0;
    reset = 0;
    #1;
    modelReset();
    e = modelOutputs();
    checkOutput("reset_outputs",
                32'({game_start, game_done, mole_leds, hit_pulse, score_tens, score_ones}),
                32'(e));
    repeat (3) @(negedge Clock);
    reset = 1;
    driveCycle(0, 4'd0, 0);
  endtask

  task automatic waitMole(output bit ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (moleUp()) begin
        ok = 1;
        break;
      end
      applyStimulus(0, 4'd0, 0);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_mole actual=no_mole expected=mole_lit at %0t", $time);
    end
  endtask

  task automatic hitMole();
    bit ok;
    waitMole(ok);
    if (ok) begin
      applyStimulus(0, 4'(1 << m_lit), 0);
      applyStimulus(0, 4'd0, 0);
    end
  endtask

  initial begin : monitor
    expect_t e;
    forever begin
      @(posedge Clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("flags", 32'({game_start, game_done, hit_pulse}), 32'({e.gs, e.gd, e.hp}));
        checkOutput("mole_leds", 32'(mole_leds), 32'(e.leds));
        checkOutput("score", 32'({score_tens, score_ones}), 32'({e.tens, e.ones}));
      end
    end
  end

  initial begin : driver
    bit ok;
    int guard;
    int wrong;
    expect_t e;
    modelReset();
    #1;
    e = modelOutputs();
    checkOutput("reset_outputs",
                32'({game_start, game_done, mole_leds, hit_pulse, score_tens, score_ones}),
                32'(e));
    repeat (2) @(negedge Clock);
    reset = 1;
    driveCycle(0, 4'd0, 0);

    // Start, play into UP, then reset mid-mole and start again.
    repeat (3) applyStimulus(0, 4'd0, 0);
    applyStimulus(1, 4'd0, 0);
    applyStimulus(0, 4'd0, 0);
    waitMole(ok);
    applyStimulus(0, 4'd0, 0);
    doReset();
    repeat (2) applyStimulus(0, 4'd0, 0);
    applyStimulus(1, 4'd0, 0);
    applyStimulus(0, 4'd0, 0);

    repeat (3) hitMole();

    // Let moles time out untouched.
    repeat (30) applyStimulus(0, 4'd0, 0);

    // Wrong key, then the lit key together with another one.
    waitMole(ok);
    if (ok) begin
      wrong = (m_lit + 1) % N;
      applyStimulus(0, 4'(1 << wrong), 0);
      applyStimulus(0, 4'd0, 0);
      applyStimulus(0, 4'((1 << m_lit) | (1 << ((m_lit + 2) % N))), 0);
      applyStimulus(0, 4'd0, 0);
    end

    // Climb to the 99 ceiling and push past it.
    guard = 0;
    while (m_score < 99 && guard < 200) begin
      hitMole();
      guard++;
    end
    repeat (2) hitMole();

    // Time-up in the same cycle as a hit edge, then restart from DONE.
    waitMole(ok);
    if (ok) applyStimulus(0, 4'(1 << m_lit), 1);
    repeat (3) applyStimulus(0, 4'd0, 0);
    applyStimulus(1, 4'd0, 0);
    applyStimulus(0, 4'd0, 0);

    // Time-up while the hit is being scored.
    waitMole(ok);
    if (ok) begin
      applyStimulus(0, 4'(1 << m_lit), 0);
      applyStimulus(0, 4'd0, 1);
    end
    repeat (3) applyStimulus(0, 4'd0, 0);
    applyStimulus(1, 4'd0, 0);

    // Random play.
    for (int i = 0; i < 500; i++) begin
      logic [3:0] h;
      bit s, t;
      s = ($urandom_range(0, 29) == 0);
      t = ($urandom_range(0, 149) == 0);
      if (moleUp() && $urandom_range(0, 2) == 0) h = 4'(1 << m_lit);
      else if ($urandom_range(0, 3) == 0) h = 4'($urandom_range(0, 15));
      else h = 4'd0;
      applyStimulus(s, h, t);
    end

    repeat (2) applyStimulus(0, 4'd0, 0);
    repeat (2) @(negedge Clock);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
